// File: rtl/ofs_fim_axis_rr_arbiter_if.sv
// AXI-Stream bundle used on both sides of the round-robin arbiter.
// LANES parallel streams share one bundle; payload fields are flattened lane by lane.
//
// Handshake: a beat transfers on a cycle where tvalid & tready are both high at the
// rising clock edge. The producer must not change tvalid or payload while tvalid=1 and
// tready=0; tready may depend combinationally on the sink's own downstream ready.
interface ofs_fim_axis_rr_arbiter_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int USER_W = 10
);
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES-1:0]        tlast;
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES*USER_W-1:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/ofs_fim_axis_rr_arbiter.sv
// Packet-level round-robin merge of NUM_SRC AXI-Stream sources onto one registered
// AXIS master; a grant is held until tlast (PKT_MODE=1) or a single beat (PKT_MODE=0).
module ofs_fim_axis_rr_arbiter #(
    parameter  int NUM_SRC     = 4,
    parameter  int TDATA_WIDTH = 512,
    parameter  int TUSER_WIDTH = 10,
    parameter  int PKT_MODE    = 1,
    localparam int SEL_WIDTH   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ofs_fim_axis_rr_arbiter_if.slave  s,
    ofs_fim_axis_rr_arbiter_if.master m,
    output logic [SEL_WIDTH-1:0]   m_tid,
    output logic                   busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d;
    logic [SEL_WIDTH-1:0] last_q, last_d;
    logic [SEL_WIDTH-1:0] pick;
    logic [SEL_WIDTH-1:0] cand;
    logic                 pick_vld;
    logic                 out_en;
    logic                 accept;
    logic                 end_pkt;
    logic [NUM_SRC-1:0]   ready_vec;

    logic                   m_vld_q;
    logic [TDATA_WIDTH-1:0] m_data_q;
    logic [TKEEP_WIDTH-1:0] m_keep_q;
    logic [TUSER_WIDTH-1:0] m_user_q;
    logic                   m_last_q;
    logic [SEL_WIDTH-1:0]   m_tid_q;

    // Output register can take a new beat when empty or being drained this cycle.
    assign out_en  = ~m_vld_q | m.tready[0];
    assign accept  = (state_q == ST_LOCKED) & s.tvalid[grant_q] & out_en;
    assign end_pkt = accept & (s.tlast[grant_q] | (PKT_MODE == 0));

    // Rotating priority search: walk downward so the requester closest after
    // last_q is the final (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = SEL_WIDTH'((int'(last_q) + k) % NUM_SRC);
            if (s.tvalid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ready_vec = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                ready_vec[grant_q] = out_en;
                if (end_pkt) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= SEL_WIDTH'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld_q <= 1'b0;
        end else if (out_en) begin
            m_vld_q <= accept;
        end
    end

    // Payload needs no reset: it is only meaningful while m_vld_q is set.
    always_ff @(posedge clk) begin
        if (out_en) begin
            m_data_q <= s.tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
            m_keep_q <= s.tkeep[int'(grant_q)*TKEEP_WIDTH +: TKEEP_WIDTH];
            m_user_q <= s.tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH];
            m_last_q <= s.tlast[grant_q];
            m_tid_q  <= grant_q;
        end
    end

    assign s.tready = ready_vec;
    assign m.tvalid = m_vld_q;
    assign m.tdata  = m_data_q;
    assign m.tkeep  = m_keep_q;
    assign m.tuser  = m_user_q;
    assign m.tlast  = m_last_q;
    assign m_tid    = m_tid_q;
    assign busy     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ofs_fim_axis_rr_arbiter.sv
// Self-checking bench for the AXIS round-robin arbiter: directed corner cases plus
// randomized packet traffic scored against a rotation model of the expected stream.
module tb_ofs_fim_axis_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 4;
  localparam int IW = 2;
  localparam int BW = 1 + UW + KW + DW;
  localparam int EW = IW + BW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ofs_fim_axis_rr_arbiter_if #(.LANES(NS), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) s_if ();
  ofs_fim_axis_rr_arbiter_if #(.LANES(1),  .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) m_if ();
  ofs_fim_axis_rr_arbiter_if #(.LANES(NS), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) sb_if ();
  ofs_fim_axis_rr_arbiter_if #(.LANES(1),  .DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) mb_if ();
  logic [IW-1:0] m_tid, mb_tid;
  logic          busy, busy_b;

  ofs_fim_axis_rr_arbiter #(.NUM_SRC(NS), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .PKT_MODE(1)) u_dut (
    .clk(clk), .rst(rst), .s(s_if), .m(m_if), .m_tid(m_tid), .busy(busy)
  );

  ofs_fim_axis_rr_arbiter #(.NUM_SRC(NS), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .PKT_MODE(0)) u_dut_b (
    .clk(clk), .rst(rst), .s(sb_if), .m(mb_if), .m_tid(mb_tid), .busy(busy_b)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [BW-1:0] src_beats [NS][64];
  int src_n [NS];
  int src_rd [NS];
  int src_start [NS];
  int pkt_off [NS][16];
  int pkt_len [NS][16];
  int pkt_cnt [NS];
  logic [EW-1:0] exp_q[$];
  bit gap_en;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    s_if.tvalid = '0;  s_if.tlast = '0;  s_if.tdata = '0;  s_if.tkeep = '0;  s_if.tuser = '0;
    sb_if.tvalid = '0; sb_if.tlast = '0; sb_if.tdata = '0; sb_if.tkeep = '0; sb_if.tuser = '0;
    m_if.tready = 1'b1;
    mb_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NS; s++) begin
      src_n[s] = 0; src_rd[s] = 0; src_start[s] = 0; pkt_cnt[s] = 0;
    end
    exp_q.delete();
    gap_en = 1'b0;
  endtask

  task automatic add_pkt(input int s, input int len);
    pkt_off[s][pkt_cnt[s]] = src_n[s];
    pkt_len[s][pkt_cnt[s]] = len;
    for (int b = 0; b < len; b++) begin
      src_beats[s][src_n[s]] = {1'(b == len - 1), UW'($urandom), KW'($urandom), DW'($urandom)};
      src_n[s]++;
    end
    pkt_cnt[s]++;
  endtask

  task automatic expect_pkt(input int s, input int k);
    for (int b = 0; b < pkt_len[s][k]; b++)
      exp_q.push_back({IW'(s), src_beats[s][pkt_off[s][k] + b]});
  endtask

  // Reference: sources with packets left are always requesting at packet
  // boundaries, so packet order is a pure rotation over non-empty sources.
  task automatic model_rr();
    int last;
    int nxt [NS];
    bit found;
    last = NS - 1;
    for (int s = 0; s < NS; s++) nxt[s] = 0;
    do begin
      found = 1'b0;
      for (int k = 1; k <= NS && !found; k++) begin
        int c;
        c = (last + k) % NS;
        if (nxt[c] < pkt_cnt[c]) begin
          expect_pkt(c, nxt[c]);
          nxt[c]++;
          last  = c;
          found = 1'b1;
        end
      end
    end while (found);
  endtask

  task automatic drive_src(input int cyc);
    logic [BW-1:0] bt;
    bit has, in_pkt, v;
    for (int s = 0; s < NS; s++) begin
      has    = (src_rd[s] < src_n[s]) && (cyc >= src_start[s]);
      in_pkt = has && (src_rd[s] > 0) && !src_beats[s][src_rd[s] - 1][BW-1];
      bt     = has ? src_beats[s][src_rd[s]] : '0;
      v      = has && !(gap_en && in_pkt && ($urandom_range(0, 3) == 0));
      s_if.tvalid[s]          = v;
      s_if.tdata[s*DW +: DW]  = bt[DW-1:0];
      s_if.tkeep[s*KW +: KW]  = bt[DW +: KW];
      s_if.tuser[s*UW +: UW]  = bt[DW+KW +: UW];
      s_if.tlast[s]           = bt[BW-1];
    end
  endtask

  task automatic run_traffic(input int budget, input int rdy_pct, input int st_lo, input int st_hi);
    int cyc;
    bit hold;
    logic [EW-1:0] got, e;
    cyc  = 0;
    hold = 1'b0;
    while (exp_q.size() > 0 && cyc < budget) begin
      drive_src(cyc);
      m_if.tready[0] = (cyc >= st_lo && cyc < st_hi) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      check_eq("sready_onehot0", 64'($onehot0(s_if.tready)), 64'd1);
      if (m_if.tvalid[0] && !m_if.tready[0]) check_eq("stall_sready", 64'(s_if.tready), 64'd0);
      if (hold) check_eq("stall_hold_valid", 64'(m_if.tvalid), 64'd1);
      for (int s = 0; s < NS; s++)
        if (s_if.tvalid[s] && s_if.tready[s]) src_rd[s]++;
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        got = {m_tid, m_if.tlast[0], m_if.tuser, m_if.tkeep, m_if.tdata};
        e   = exp_q.pop_front();
        check_eq("out_beat", 64'(got), 64'(e));
      end
      hold = m_if.tvalid[0] && !m_if.tready[0];
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("beats_left", 64'(exp_q.size()), 64'd0);
    s_if.tvalid = '0;
    m_if.tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("no_extra_beat", 64'(m_if.tvalid), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt, np, tq[$];
    logic [DW-1:0] dq[$];
    bit seen;
    int i0, i3;

    clear_srcs();
    do_reset();

    // reset state
    @(negedge clk);
    check_eq("rst_mvalid", 64'(m_if.tvalid), 64'd0);
    check_eq("rst_sready", 64'(s_if.tready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mvalid_b", 64'(mb_if.tvalid), 64'd0);
    @(posedge clk); #1;

    // first-grant latency from IDLE
    do_reset();
    s_if.tvalid = 4'b0100; s_if.tlast = 4'b0100;
    s_if.tdata[2*DW +: DW] = 32'hC0DE_0002;
    @(negedge clk);
    check_eq("lat_c0_sready", 64'(s_if.tready), 64'd0);
    check_eq("lat_c0_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("lat_c1_sready", 64'(s_if.tready), 64'h4);
    check_eq("lat_c1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    s_if.tvalid = '0;
    @(negedge clk);
    check_eq("lat_c2_mvalid", 64'(m_if.tvalid), 64'd1);
    check_eq("lat_c2_tid", 64'(m_tid), 64'd2);
    check_eq("lat_c2_tdata", 64'(m_if.tdata), 64'hC0DE_0002);
    @(posedge clk); #1;

    // all four requesting, single-beat packets: 0,1,2,3,0 with a bubble between
    do_reset();
    s_if.tvalid = '1; s_if.tlast = '1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check_eq("rot_mvalid", 64'(m_if.tvalid), 64'(k >= 2 && k % 2 == 0));
      if (k >= 2 && k % 2 == 0) check_eq("rot_tid", 64'(m_tid), 64'(((k - 2) / 2) % NS));
      @(posedge clk); #1;
    end

    // source 2 three-beat packet, source 1 joins on beat 2
    do_reset(); clear_srcs();
    add_pkt(2, 3); add_pkt(1, 1);
    src_start[1] = 2;
    expect_pkt(2, 0); expect_pkt(1, 0);
    run_traffic(100, 100, -1, -1);

    // five-cycle downstream stall mid-packet
    do_reset(); clear_srcs();
    add_pkt(0, 6);
    expect_pkt(0, 0);
    run_traffic(100, 100, 3, 8);

    // source 3 first, then only source 1: search wraps past 3
    do_reset(); clear_srcs();
    add_pkt(3, 1); add_pkt(1, 1);
    src_start[1] = 6;
    expect_pkt(3, 0); expect_pkt(1, 0);
    run_traffic(100, 100, -1, -1);

    // randomized traffic against the rotation model
    for (int it = 0; it < 8; it++) begin
      do_reset(); clear_srcs();
      gap_en = 1'b1;
      for (int s = 0; s < NS; s++) begin
        np = $urandom_range(0, 4);
        for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 4));
      end
      model_rr();
      run_traffic(3000, (it % 2 == 0) ? 100 : 60, -1, -1);
    end

    // PKT_MODE=0: sources 0 and 3 with 2-beat packets interleave per beat
    do_reset();
    i0 = 0; i3 = 0;
    for (int c = 0; c < 20; c++) begin
      sb_if.tvalid[0] = (i0 < 2);
      sb_if.tlast[0]  = (i0 == 1);
      sb_if.tdata[0 +: DW] = 32'hA000_0000 | DW'(i0);
      sb_if.tvalid[3] = (i3 < 2);
      sb_if.tlast[3]  = (i3 == 1);
      sb_if.tdata[3*DW +: DW] = 32'hB000_0000 | DW'(i3);
      @(negedge clk);
      if (sb_if.tvalid[0] && sb_if.tready[0]) i0++;
      if (sb_if.tvalid[3] && sb_if.tready[3]) i3++;
      if (mb_if.tvalid[0]) begin
        tq.push_back(int'(mb_tid));
        dq.push_back(mb_if.tdata);
      end
      @(posedge clk); #1;
    end
    check_eq("pm0_count", 64'(tq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < tq.size()) begin
        check_eq("pm0_tid", 64'(tq[i]), 64'((i % 2) * 3));
        check_eq("pm0_data", 64'(dq[i]), 64'(((i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) | (i / 2)));
      end
    end

    // reset asserted on beat 2 of a packet
    do_reset();
    s_if.tvalid = 4'b0010; s_if.tlast = '0;
    s_if.tdata[1*DW +: DW] = 32'h1111_0001;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 2; k++) begin
      @(negedge clk);
      if (m_if.tvalid[0]) cnt++;
      if (cnt < 2) begin @(posedge clk); #1; end
    end
    check_eq("rstmid_reached", 64'(cnt), 64'd2);
    rst = 1'b1;
    #1;
    check_eq("rstmid_mvalid", 64'(m_if.tvalid), 64'd0);
    check_eq("rstmid_sready", 64'(s_if.tready), 64'd0);
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    s_if.tvalid = 4'b1011; s_if.tlast = '1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_if.tvalid[0]) begin seen = 1'b1; break; end
    end
    check_eq("rstmid_restart_seen", 64'(seen), 64'd1);
    check_eq("rstmid_restart_tid", 64'(m_tid), 64'd0);
    @(posedge clk); #1;
    do_reset();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=1 exp=0");
    $fatal(1, "watchdog");
  end
endmodule
